// File: rtl/tee_comm_mbox_pkg.sv
// Shared constants and types for the TEE/host communication mailbox.
package tee_comm_pkg;
  localparam int MBOX_DATA_W = 32;
  localparam int MBOX_DEPTH  = 8;
  localparam int MBOX_LVL_W  = $clog2(MBOX_DEPTH + 1);

  typedef logic [MBOX_DATA_W-1:0] mbox_word_t;
  typedef logic [MBOX_LVL_W-1:0]  mbox_level_t;

  function automatic bit is_pow2(int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/tee_comm_mbox_if.sv
// Mailbox signal bundle: h2t is pushed by the host and popped by the TEE, t2h the reverse.
// Handshake: a word moves on a rising edge exactly when valid && ready; ready/valid never depend on the peer.
interface tee_comm_mbox_if
  import tee_comm_pkg::*;
#(
  parameter int DATA_W = MBOX_DATA_W,
  parameter int DEPTH  = MBOX_DEPTH
);
  logic                         h2t_wvalid;
  logic                         h2t_wready;
  logic [DATA_W-1:0]            h2t_wdata;
  logic                         h2t_rvalid;
  logic                         h2t_rready;
  logic [DATA_W-1:0]            h2t_rdata;
  logic                         t2h_wvalid;
  logic                         t2h_wready;
  logic [DATA_W-1:0]            t2h_wdata;
  logic                         t2h_rvalid;
  logic                         t2h_rready;
  logic [DATA_W-1:0]            t2h_rdata;
  logic [$clog2(DEPTH+1)-1:0]   h2t_level;
  logic [$clog2(DEPTH+1)-1:0]   t2h_level;
  logic                         irq_tee;
  logic                         irq_host;

  modport master (
    output h2t_wvalid, h2t_wdata, h2t_rready, t2h_wvalid, t2h_wdata, t2h_rready,
    input  h2t_wready, h2t_rvalid, h2t_rdata, t2h_wready, t2h_rvalid, t2h_rdata,
    input  h2t_level, t2h_level, irq_tee, irq_host
  );

  modport slave (
    input  h2t_wvalid, h2t_wdata, h2t_rready, t2h_wvalid, t2h_wdata, t2h_rready,
    output h2t_wready, h2t_rvalid, h2t_rdata, t2h_wready, t2h_rvalid, t2h_rdata,
    output h2t_level, t2h_level, irq_tee, irq_host
  );
endinterface

// File: rtl/tee_comm_mbox_fifo.sv
// First-word fall-through queue for one mailbox direction; flags are registered from the next level.
module tee_mbox_fifo
  import tee_comm_pkg::*;
#(
  parameter int DATA_W = MBOX_DATA_W,
  parameter int DEPTH  = MBOX_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("tee_mbox_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wready_q, rvalid_q;
  logic              push, pop;

  assign push = wvalid_i && wready_q;
  assign pop  = rready_i && rvalid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // wready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      wready_q <= (level_d != FULL_LVL);
      rvalid_q <= (level_d != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Storage is not reset, so the head is masked to zero while the queue is empty.
  assign rdata_o  = rvalid_q ? mem_q[rd_ptr_q] : '0;
  assign wready_o = wready_q;
  assign rvalid_o = rvalid_q;
  assign level_o  = level_q;
endmodule

// File: rtl/tee_comm_mbox.sv
// Two independent mailbox queues plus optional level doorbells.
// Define TEE_COMM_MBOX_IRQ_EN to enable the doorbells; otherwise irq_tee/irq_host are tied low.
module tee_comm_mbox
  import tee_comm_pkg::*;
#(
  parameter int DATA_W     = MBOX_DATA_W,
  parameter int DEPTH      = MBOX_DEPTH,
  parameter int IRQ_THRESH = 1
) (
  input logic            s00_axi_aclk,
  input logic            s00_axi_aresetn,
  tee_comm_mbox_if.slave mbox
);
  if ((IRQ_THRESH < 1) || (IRQ_THRESH > DEPTH)) begin : g_bad_thresh
    $error("tee_comm_mbox: IRQ_THRESH must lie in 1..DEPTH");
  end

  tee_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_h2t (
    .clk_i    (s00_axi_aclk),
    .rst_ni   (s00_axi_aresetn),
    .wvalid_i (mbox.h2t_wvalid),
    .wready_o (mbox.h2t_wready),
    .wdata_i  (mbox.h2t_wdata),
    .rvalid_o (mbox.h2t_rvalid),
    .rready_i (mbox.h2t_rready),
    .rdata_o  (mbox.h2t_rdata),
    .level_o  (mbox.h2t_level)
  );

  tee_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_t2h (
    .clk_i    (s00_axi_aclk),
    .rst_ni   (s00_axi_aresetn),
    .wvalid_i (mbox.t2h_wvalid),
    .wready_o (mbox.t2h_wready),
    .wdata_i  (mbox.t2h_wdata),
    .rvalid_o (mbox.t2h_rvalid),
    .rready_i (mbox.t2h_rready),
    .rdata_o  (mbox.t2h_rdata),
    .level_o  (mbox.t2h_level)
  );

`ifdef TEE_COMM_MBOX_IRQ_EN
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] THRESH = LVL_W'(IRQ_THRESH);

  logic irq_tee_q, irq_host_q;

  // Doorbells trail the level by one edge.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      irq_tee_q  <= 1'b0;
      irq_host_q <= 1'b0;
    end else begin
      irq_tee_q  <= (mbox.h2t_level >= THRESH);
      irq_host_q <= (mbox.t2h_level >= THRESH);
    end
  end

  assign mbox.irq_tee  = irq_tee_q;
  assign mbox.irq_host = irq_host_q;
`else
  assign mbox.irq_tee  = 1'b0;
  assign mbox.irq_host = 1'b0;
`endif
endmodule

// File: tb/tb_tee_comm_mbox.sv
// Directed plus random stimulus for tee_comm_mbox, checked against a queue-based reference model.
module tb_tee_comm_mbox;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int THRESH = 2;
`ifdef TEE_COMM_MBOX_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  tee_comm_mbox_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) mbox ();

  tee_comm_mbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .mbox            (mbox)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per direction, plus registered ready and doorbell expectations.
  logic [DATA_W-1:0] h2t_q[$];
  logic [DATA_W-1:0] t2h_q[$];
  bit h2t_ok, t2h_ok;
  bit irq_tee_exp, irq_host_exp;
  int n_cmp, n_fail;

  task automatic chk(string tag, logic [DATA_W-1:0] obs, logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    mbox.h2t_wvalid = 1'b0;
    mbox.h2t_wdata  = '0;
    mbox.h2t_rready = 1'b0;
    mbox.t2h_wvalid = 1'b0;
    mbox.t2h_wdata  = '0;
    mbox.t2h_rready = 1'b0;
  endtask

  task automatic check_all();
    chk("h2t_level",  {28'd0, mbox.h2t_level}, h2t_q.size());
    chk("t2h_level",  {28'd0, mbox.t2h_level}, t2h_q.size());
    chk("h2t_rvalid", {31'd0, mbox.h2t_rvalid}, {31'd0, h2t_q.size() > 0});
    chk("t2h_rvalid", {31'd0, mbox.t2h_rvalid}, {31'd0, t2h_q.size() > 0});
    chk("h2t_wready", {31'd0, mbox.h2t_wready}, {31'd0, h2t_ok});
    chk("t2h_wready", {31'd0, mbox.t2h_wready}, {31'd0, t2h_ok});
    chk("irq_tee",    {31'd0, mbox.irq_tee}, {31'd0, irq_tee_exp});
    chk("irq_host",   {31'd0, mbox.irq_host}, {31'd0, irq_host_exp});
    if (h2t_q.size() > 0) chk("h2t_rdata", mbox.h2t_rdata, h2t_q[0]);
    else chk("h2t_rdata_known", {31'd0, $isunknown(mbox.h2t_rdata)}, '0);
    if (t2h_q.size() > 0) chk("t2h_rdata", mbox.t2h_rdata, t2h_q[0]);
    else chk("t2h_rdata_known", {31'd0, $isunknown(mbox.t2h_rdata)}, '0);
  endtask

  // Advance one clock edge, apply the sampled transfers to the model, then check everything.
  task automatic step();
    bit rst_s, h_push, h_pop, t_push, t_pop;
    logic [DATA_W-1:0] h_d, t_d;
    int h_pre, t_pre;
    rst_s  = rst_n;
    h_pre  = h2t_q.size();
    t_pre  = t2h_q.size();
    h_push = mbox.h2t_wvalid && h2t_ok;
    h_pop  = mbox.h2t_rready && (h_pre > 0);
    t_push = mbox.t2h_wvalid && t2h_ok;
    t_pop  = mbox.t2h_rready && (t_pre > 0);
    h_d    = mbox.h2t_wdata;
    t_d    = mbox.t2h_wdata;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      h2t_q.delete();
      t2h_q.delete();
      h2t_ok       = 1'b0;
      t2h_ok       = 1'b0;
      irq_tee_exp  = 1'b0;
      irq_host_exp = 1'b0;
    end else begin
      if (h_pop)  void'(h2t_q.pop_front());
      if (h_push) h2t_q.push_back(h_d);
      if (t_pop)  void'(t2h_q.pop_front());
      if (t_push) t2h_q.push_back(t_d);
      h2t_ok       = h2t_q.size() < DEPTH;
      t2h_ok       = t2h_q.size() < DEPTH;
      irq_tee_exp  = IRQ_EN && (h_pre >= THRESH);
      irq_host_exp = IRQ_EN && (t_pre >= THRESH);
    end
    check_all();
  endtask

  task automatic drain_all();
    idle_in();
    mbox.h2t_rready = 1'b1;
    mbox.t2h_rready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && (h2t_q.size() > 0 || t2h_q.size() > 0); i++) step();
    idle_in();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    h2t_ok = 1'b0;
    t2h_ok = 1'b0;
    irq_tee_exp = 1'b0;
    irq_host_exp = 1'b0;
    idle_in();
    rst_n = 1'b0;

    // Reset and first cycle after release.
    step();
    step();
    chk("rst_h2t_rdata", mbox.h2t_rdata, '0);
    chk("rst_wready_low", {31'd0, mbox.h2t_wready}, '0);
    rst_n = 1'b1;
    step();
    chk("post_rst_wready", {31'd0, mbox.h2t_wready}, 32'd1);
    chk("post_rst_level", {28'd0, mbox.h2t_level}, '0);

    // Four words in order through h2t.
    for (int i = 1; i <= 4; i++) begin
      mbox.h2t_wvalid = 1'b1;
      mbox.h2t_wdata  = DATA_W'(i);
      step();
    end
    idle_in();
    mbox.h2t_rready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("seq_rdata", mbox.h2t_rdata, DATA_W'(i));
      step();
    end
    idle_in();
    chk("seq_level_zero", {28'd0, mbox.h2t_level}, '0);
    chk("seq_t2h_untouched", {28'd0, mbox.t2h_level}, '0);

    // Fill, then a push together with a pop while full.
    for (int i = 0; i < DEPTH; i++) begin
      mbox.h2t_wvalid = 1'b1;
      mbox.h2t_wdata  = $urandom;
      step();
    end
    chk("full_level", {28'd0, mbox.h2t_level}, DEPTH);
    chk("full_wready", {31'd0, mbox.h2t_wready}, '0);
    mbox.h2t_wdata  = 32'hDEAD_BEEF;
    mbox.h2t_rready = 1'b1;
    step();
    chk("full_pushpop_level", {28'd0, mbox.h2t_level}, DEPTH - 1);
    chk("full_wready_rise", {31'd0, mbox.h2t_wready}, 32'd1);
    drain_all();

    // Streaming across pointer wrap at constant level.
    for (int i = 0; i < 3; i++) begin
      mbox.h2t_wvalid = 1'b1;
      mbox.h2t_wdata  = $urandom;
      step();
    end
    mbox.h2t_rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mbox.h2t_wdata = $urandom;
      step();
      chk("stream_level", {28'd0, mbox.h2t_level}, 32'd3);
    end
    drain_all();

    // Doorbell on t2h.
    mbox.t2h_wvalid = 1'b1;
    mbox.t2h_wdata  = 32'h11;
    step();
    mbox.t2h_wdata  = 32'h22;
    step();
    idle_in();
    chk("irq_lag", {31'd0, mbox.irq_host}, '0);
    step();
`ifdef TEE_COMM_MBOX_IRQ_EN
    chk("irq_set", {31'd0, mbox.irq_host}, 32'd1);
`else
    chk("irq_off", {31'd0, mbox.irq_host}, '0);
`endif
    mbox.t2h_rready = 1'b1;
    step();
    idle_in();
    step();
    chk("irq_clear", {31'd0, mbox.irq_host}, '0);
    drain_all();

    // Reset with five words queued, then recover.
    for (int i = 0; i < 5; i++) begin
      mbox.h2t_wvalid = 1'b1;
      mbox.h2t_wdata  = $urandom;
      step();
    end
    idle_in();
    chk("pre_rst_level", {28'd0, mbox.h2t_level}, 32'd5);
    rst_n = 1'b0;
    step();
    chk("mid_rst_level", {28'd0, mbox.h2t_level}, '0);
    chk("mid_rst_rvalid", {31'd0, mbox.h2t_rvalid}, '0);
    rst_n = 1'b1;
    step();
    mbox.h2t_wvalid = 1'b1;
    mbox.h2t_wdata  = 32'hA5;
    step();
    idle_in();
    chk("post_rst_a5", mbox.h2t_rdata, 32'hA5);
    drain_all();

    // Random traffic on both directions with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      mbox.h2t_wvalid = $urandom_range(0, 1);
      mbox.h2t_wdata  = $urandom;
      mbox.h2t_rready = $urandom_range(0, 2) == 0;
      mbox.t2h_wvalid = $urandom_range(0, 2) != 0;
      mbox.t2h_wdata  = $urandom;
      mbox.t2h_rready = $urandom_range(0, 1);
      step();
    end
    rst_n = 1'b1;
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tee_comm_mbox.md
TEE_COMM_MBOX -- requirements
Module: tee_comm_mbox

Interface
REQ-001 Parameter DATA_W, default 32, shall set the mailbox word width in bits.
REQ-002 Parameter DEPTH, default 8, shall set the entries per direction; it shall be a power of two and at least 2.
REQ-003 Parameter IRQ_THRESH, default 1, shall set the queue level (1..DEPTH) at which a doorbell asserts.
REQ-004 s00_axi_aclk  in  1  shall be the single clock; all logic is on its rising edge.
REQ-005 s00_axi_aresetn  in  1  shall be the reset: synchronous, active-low.
REQ-006 h2t_wvalid  in  1  shall be the host push request.
REQ-007 h2t_wready  out  1  shall indicate the host-to-TEE queue can accept a word.
REQ-008 h2t_wdata  in  DATA_W  shall carry the host push data.
REQ-009 h2t_rvalid  out  1  shall indicate the host-to-TEE queue head is valid for the TEE.
REQ-010 h2t_rready  in  1  shall be the TEE pop request.
REQ-011 h2t_rdata  out  DATA_W  shall carry the host-to-TEE queue head word.
REQ-012 t2h_wvalid, t2h_wready, t2h_wdata, t2h_rvalid, t2h_rready, t2h_rdata shall mirror REQ-006..011 for the TEE-to-host direction, with the TEE pushing and the host popping.
REQ-013 h2t_level, t2h_level  out  $clog2(DEPTH+1)  shall give the occupancy of each queue.
REQ-014 irq_tee, irq_host  out  1  shall be the doorbells for the h2t and t2h queues respectively.

Function
REQ-015 The two directions shall be fully independent and shall have identical behaviour.
REQ-016 Push shall occur when wvalid&&wready; pop shall occur when rvalid&&rready.
REQ-017 Queue behaviour:
- wready = !full and rvalid = !empty, both driven from registered state.
- The queue shall be first-word fall-through: rdata equals the head whenever rvalid=1.
- rdata shall hold its value while rvalid=1 and no pop occurs.
REQ-018 Latency: a word pushed into an empty queue at edge N shall give rvalid=1 and valid rdata after edge N, with no bypass in the same cycle.
REQ-019 Full queue: wready=0, so no push is accepted even if a pop occurs in the same cycle; wready shall rise the cycle after the pop.
REQ-020 Empty queue: rvalid=0, so rready shall be ignored and the level shall never underflow.
REQ-021 Simultaneous push and pop on a non-full, non-empty queue shall leave the level unchanged and preserve FIFO order.
REQ-022 Pointers shall be log2(DEPTH) bits wide and wrap modulo DEPTH; full and empty shall be derived from the level counter.
REQ-023 The level shall update exactly as +1 on push only, -1 on pop only, and 0 otherwise.
REQ-024 rdata while rvalid=0 is don't-care but shall not be X after reset.

Reset
REQ-025 While aresetn=0 at a clock edge:
- Both queues shall empty and all pointers shall clear.
- Outputs shall be: level=0, wready=1 only after reset deasserts (0 during reset), rvalid=0, irq=0, rdata=0.
REQ-026 Reset asserted mid-operation shall discard all queued words; the first edge with aresetn=1 shall resume from the empty state.

Configuration
REQ-027 With TEE_COMM_MBOX_IRQ_EN defined, each doorbell shall be a registered copy of (level >= IRQ_THRESH), asserting one cycle after the level crosses the threshold.
REQ-028 Without TEE_COMM_MBOX_IRQ_EN, irq_tee and irq_host shall be constant 0 and no threshold logic shall be synthesised.

Structure
REQ-029 Package tee_comm_pkg shall hold MBOX_DATA_W, MBOX_DEPTH, and the typedefs mbox_word_t and mbox_level_t.
REQ-030 Sub-module tee_mbox_fifo (storage, pointers, level, flags) shall be instantiated once per direction; the top level adds only the doorbell logic.

Verification
REQ-031 The bench shall cover:
- Reset -> h2t_level=0, h2t_rvalid=0, irq_tee=0, h2t_wready=1 on the first cycle after deassertion.
- Push 0x1,0x2,0x3,0x4 into h2t, then pop 4 -> rdata sequence 0x1..0x4, level returns to 0, t2h untouched.
- Push 8 words (DEPTH=8) -> wready=0 at level 8; a 9th push with a same-cycle pop -> push rejected, level=7, wready=1 next cycle.
- Continuous push and pop for 20 words with DEPTH=8 -> order preserved across pointer wrap, level constant.
- With TEE_COMM_MBOX_IRQ_EN and IRQ_THRESH=2, push 2 words into t2h -> irq_host=1 one cycle after level=2; pop 1 -> irq_host=0 one cycle later.
- Assert reset with level=5 -> level=0, rvalid=0 next cycle; a subsequent push of 0xA5 -> rdata=0xA5.
